mult_div_unit: RTL
==================

# mult_div_unit

Parametrised iterative multiply/divide unit with HI/LO accumulator. It is the next-generation HI/LO engine for the pipelined MIPS core and sits in the EX stage beside the ALU. It extends the fixed 32-bit unit with configurable width and multiply latency, a true bit-serial divider, madd/msub accumulate modes, defined divide-by-zero results, and an exception cancel that aborts an operation in flight.

## Interface

**Parameters**

- WIDTH, 32: operand and HI/LO width; must be even and ≥ 8.
- MUL_CYCLES, 5: busy cycles for multiply and accumulate ops; must be ≥ 1.

**Ports**

- clk in 1: single clock; all state updates on the rising edge.
- rst in 1: asynchronous, active-low reset.
- start in 1: launch the operation in op; sampled at the edge.
- op in 3: operation code from md_pkg.
- d1 in WIDTH: rs operand (dividend / multiplicand).
- d2 in WIDTH: rt operand (divisor / multiplier).
- we in 1: direct HI/LO write (mthi/mtlo).
- hilo_sel in 1: target for we: 0 = HI, 1 = LO.
- cancel in 1: exception taken; abort the current operation and ignore start/we in this cycle.
- busy out 1: an operation is in flight.
- done out 1: one-cycle pulse after HI/LO are updated by a completed operation.
- hi out WIDTH: HI register.
- lo out WIDTH: LO register.

## Operation

- Operations:
  - MULT/MULTU: {HI,LO} = d1×d2, signed/unsigned, 2·WIDTH-bit result.
  - MADD/MADDU: {HI,LO} += product.
  - MSUB/MSUBU: {HI,LO} −= product.
  - Accumulate wraps modulo 2^(2·WIDTH).
- The multiply product is formed at launch and latched with operands. The accumulate uses HI/LO as they stand at completion.
- DIV/DIVU:
  - Restoring divider, one quotient bit per cycle on operand magnitudes.
  - Sign fix on the final cycle: quotient negative iff the operand signs differ; remainder takes the sign of the dividend.
  - LO = quotient, HI = remainder.
- Divide by zero (either signedness): LO = all-ones, HI = d1.
- Signed overflow, MIN / −1: LO = MIN, HI = 0.
- FSM states and transitions:
  - IDLE → MUL on start with a mul-class op.
  - IDLE → DIV on start with a div-class op.
  - MUL/DIV count down; on the last cycle HI/LO are written and the FSM returns to IDLE.
- Cancel has priority over everything:
  - In MUL/DIV it returns the FSM to IDLE at that edge, HI/LO unchanged, no done pulse.
  - In IDLE it suppresses start and we.
- start while busy is ignored. The hazard unit stalls, but the block must still be safe.
- we:
  - Honoured only when not busy and no cancel.
  - Writes d1 to the selected register at that edge.
  - start and we in the same cycle: we is ignored.

## Timing

- Reset (rst low, asynchronous): FSM IDLE, busy = 0, done = 0, hi = 0, lo = 0, counters = 0. The same applies when rst is asserted mid-operation; the operation is lost.
- busy rises at the edge that samples start and stays high for exactly:
  - MUL_CYCLES cycles for the mult/madd/msub class.
  - WIDTH cycles for div/divu, including the zero and overflow cases (fixed latency).
- HI/LO update and busy fall occur at the same edge. done is high for the one following cycle.
- A new start is accepted in the first cycle busy is low.
- we write is visible on hi/lo one cycle after the sampling edge.
- Operands are captured at the start edge; later d1/d2 changes have no effect.

## Structure

- md_pkg holds:
  - Op encodings: MD_MULT = 0, MD_MULTU = 1, MD_DIV = 2, MD_DIVU = 3, MD_MADD = 4, MD_MADDU = 5, MD_MSUB = 6, MD_MSUBU = 7.
  - FSM state encoding: MD_IDLE, MD_MUL, MD_DIV.
  - Helpers: is_div(op), is_signed(op).
- Sub-module md_divider holds:
  - The WIDTH-bit restoring core: partial remainder, quotient shift register and iteration counter.
  - Inputs: load, cancel, operand magnitudes.
  - Output: raw quotient/remainder plus a last-cycle flag.
- Sign fix, special cases, multiply/accumulate and HI/LO live in mult_div_unit.

## Test plan

All scenarios use WIDTH = 32 and MUL_CYCLES = 5.

- MULT d1 = 0xFFFFFFFF, d2 = 2 → busy high 5 cycles, then HI = 0xFFFFFFFF, LO = 0xFFFFFFFE, done pulse. MULTU on the same operands → HI = 0x00000001, LO = 0xFFFFFFFE.
- DIV d1 = 0xFFFFFFF9 (−7), d2 = 2 → busy high 32 cycles, then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 100/7 → LO = 14, HI = 2.
- DIVU 100/0 → LO = 0xFFFFFFFF, HI = 100 after 32 cycles. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- Accumulate sequence:
  - we LO = 5, then MADD 3, 4 → HI = 0, LO = 17.
  - MSUB 20, 1 → HI = 0xFFFFFFFF, LO = 0xFFFFFFFD.
  - MADDU 0xFFFFFFFF, 0xFFFFFFFF → wraps modulo 2^64.
- Cancel:
  - DIV started with HI/LO = 0x11/0x22; cancel in busy cycle 10 → busy low next edge, HI/LO stay 0x11/0x22, no done.
  - start+cancel in the same cycle → busy never rises.
  - start during busy → ignored.
- Reset: rst low mid-MULT → busy, done, hi and lo all 0 immediately without a clock edge. After release, a fresh MULT 6×7 gives LO = 42.

Source files
------------

// File: rtl/md_pkg.sv
// Shared encodings and helpers for the HI/LO multiply/divide engine.
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MADD  = 3'd4,
        MD_MADDU = 3'd5,
        MD_MSUB  = 3'd6,
        MD_MSUBU = 3'd7
    } md_op_e;

    // MD_DIV is taken by the op encoding, so the divide state is MD_DIVIDE.
    typedef enum logic [1:0] {
        MD_IDLE   = 2'd0,
        MD_MUL    = 2'd1,
        MD_DIVIDE = 2'd2
    } md_state_e;

    typedef struct packed {
        logic q_neg;
        logic r_neg;
        logic div0;
        logic ovf;
        logic acc;
        logic sub;
    } md_flags_t;

    function automatic logic is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_signed(input logic [2:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/md_divider.sv
// Bit-serial restoring divider core on unsigned magnitudes, one quotient bit per cycle.
module md_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             cancel,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q, quot_q, dvsr_q;
    logic [CW-1:0]    cnt_q;
    logic             run_q;
    logic [WIDTH:0]   shifted, diff;
    logic             qbit;
    logic [WIDTH-1:0] rem_nxt, quot_nxt;

    // The final iteration is exposed combinationally so the caller can
    // commit the result at the same edge the core performs it.
    always_comb begin
        shifted  = {rem_q, quot_q[WIDTH-1]};
        diff     = shifted - {1'b0, dvsr_q};
        qbit     = ~diff[WIDTH];
        rem_nxt  = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quot_nxt = {quot_q[WIDTH-2:0], qbit};
    end

    assign quot = quot_nxt;
    assign rem  = rem_nxt;
    assign last = run_q && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
        end else if (cancel) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (load) begin
            rem_q  <= '0;
            quot_q <= dividend;
            dvsr_q <= divisor;
            cnt_q  <= CW'(WIDTH - 1);
            run_q  <= 1'b1;
        end else if (run_q) begin
            rem_q  <= rem_nxt;
            quot_q <= quot_nxt;
            if (cnt_q == '0) begin
                run_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO accumulator for the EX stage.
// state     | meaning
// MD_IDLE   | no operation in flight; accepts start or a direct HI/LO write
// MD_MUL    | counting down the multiply/accumulate latency
// MD_DIVIDE | divider core iterating, one quotient bit per cycle
module mult_div_unit
    import md_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic             we,
    input  logic             hilo_sel,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MCW = $clog2(MUL_CYCLES + 1);

    md_state_e          state_q, state_d;
    logic [MCW-1:0]     mul_cnt_q;
    logic [2*WIDTH-1:0] prod_q, prod_d, mul_res;
    logic [WIDTH-1:0]   d1_q, hi_q, lo_q;
    md_flags_t          flags_q, flags_d;
    logic               done_q;
    logic               launch, hilo_wr, mul_fin, div_fin, sgn;
    logic [WIDTH-1:0]   mag1, mag2, div_quot, div_rem, div_hi, div_lo;
    logic               div_last;

    md_divider #(.WIDTH(WIDTH)) u_divider (
        .clk      (clk),
        .rst      (rst),
        .load     (launch && is_div(op)),
        .cancel   (cancel),
        .dividend (mag1),
        .divisor  (mag2),
        .quot     (div_quot),
        .rem      (div_rem),
        .last     (div_last)
    );

    always_comb begin
        sgn  = is_signed(op);
        mag1 = (sgn && d1[WIDTH-1]) ? -d1 : d1;
        mag2 = (sgn && d2[WIDTH-1]) ? -d2 : d2;
        // Low 2*WIDTH bits of the sign-extended product equal the signed product.
        if (sgn) begin
            prod_d = {{WIDTH{d1[WIDTH-1]}}, d1} * {{WIDTH{d2[WIDTH-1]}}, d2};
        end else begin
            prod_d = {{WIDTH{1'b0}}, d1} * {{WIDTH{1'b0}}, d2};
        end
        flags_d.q_neg = sgn && (d1[WIDTH-1] ^ d2[WIDTH-1]);
        flags_d.r_neg = sgn && d1[WIDTH-1];
        flags_d.div0  = (d2 == '0);
        flags_d.ovf   = sgn && (d1 == {1'b1, {(WIDTH-1){1'b0}}}) && (d2 == '1);
        flags_d.acc   = op[2];
        flags_d.sub   = op[2] & op[1];
    end

    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        hilo_wr = 1'b0;
        mul_fin = 1'b0;
        div_fin = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (!cancel) begin
                    if (start) begin
                        launch  = 1'b1;
                        state_d = is_div(op) ? MD_DIVIDE : MD_MUL;
                    end else if (we) begin
                        hilo_wr = 1'b1;
                    end
                end
            end
            MD_MUL: begin
                if (cancel) begin
                    state_d = MD_IDLE;
                end else if (mul_cnt_q == '0) begin
                    mul_fin = 1'b1;
                    state_d = MD_IDLE;
                end
            end
            MD_DIVIDE: begin
                if (cancel) begin
                    state_d = MD_IDLE;
                end else if (div_last) begin
                    div_fin = 1'b1;
                    state_d = MD_IDLE;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_comb begin
        mul_res = prod_q;
        if (flags_q.acc) begin
            mul_res = flags_q.sub ? ({hi_q, lo_q} - prod_q) : ({hi_q, lo_q} + prod_q);
        end
        div_lo = flags_q.q_neg ? -div_quot : div_quot;
        div_hi = flags_q.r_neg ? -div_rem : div_rem;
        if (flags_q.div0) begin
            div_lo = '1;
            div_hi = d1_q;
        end else if (flags_q.ovf) begin
            div_lo = {1'b1, {(WIDTH-1){1'b0}}};
            div_hi = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= MD_IDLE;
            mul_cnt_q <= '0;
            prod_q    <= '0;
            d1_q      <= '0;
            flags_q   <= '0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= mul_fin | div_fin;
            if (launch) begin
                prod_q    <= prod_d;
                d1_q      <= d1;
                flags_q   <= flags_d;
                mul_cnt_q <= MCW'(MUL_CYCLES - 1);
            end else if (cancel) begin
                mul_cnt_q <= '0;
            end else if (state_q == MD_MUL && mul_cnt_q != '0) begin
                mul_cnt_q <= mul_cnt_q - 1'b1;
            end
            if (mul_fin) begin
                {hi_q, lo_q} <= mul_res;
            end else if (div_fin) begin
                hi_q <= div_hi;
                lo_q <= div_lo;
            end else if (hilo_wr) begin
                if (hilo_sel) begin
                    lo_q <= d1;
                end else begin
                    hi_q <= d1;
                end
            end
        end
    end

    assign busy = (state_q != MD_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
